// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared pipeline definitions. This file holds the control-word
//                bit layout, the ALUOp encodings, the NOP control word and
//                the ID/EX stage state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Control word layout, MSB first: RegWrite, MemRead, MemWrite, MemToReg,
    // ALUSrc, Branch, ALUOp[3:0]
    localparam int CTRL_W         = 10;
    localparam int CTRL_REGWRITE  = 9;
    localparam int CTRL_MEMREAD   = 8;
    localparam int CTRL_MEMWRITE  = 7;
    localparam int CTRL_MEMTOREG  = 6;
    localparam int CTRL_ALUSRC    = 5;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_ALUOP_MSB = 3;
    localparam int CTRL_ALUOP_LSB = 0;

    // ALUOp encodings
    localparam logic [3:0] ALUOP_ADD  = 4'h0;
    localparam logic [3:0] ALUOP_SUB  = 4'h1;
    localparam logic [3:0] ALUOP_AND  = 4'h2;
    localparam logic [3:0] ALUOP_OR   = 4'h3;
    localparam logic [3:0] ALUOP_XOR  = 4'h4;
    localparam logic [3:0] ALUOP_SLL  = 4'h5;
    localparam logic [3:0] ALUOP_SRL  = 4'h6;
    localparam logic [3:0] ALUOP_SRA  = 4'h7;
    localparam logic [3:0] ALUOP_SLT  = 4'h8;
    localparam logic [3:0] ALUOP_SLTU = 4'h9;
    localparam logic [3:0] ALUOP_PASB = 4'hA;

    // An all-zero control word is a NOP: no register write, no memory access
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // ID/EX stage state
    typedef logic [0:0] state_t;
    localparam state_t RUN      = 1'b0;
    localparam state_t LU_STALL = 1'b1;

    // A slot that does not hold a real instruction must carry no side effects
    function automatic logic [CTRL_W-1:0] ctrl_gate(input logic valid,
                                                    input logic [CTRL_W-1:0] ctrl);
        return valid ? ctrl : CTRL_NOP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use hazard detector. It flags a
//                decode-slot instruction that reads the destination of a load
//                currently in EX. Register x0 never matches.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              i_valid_d,
    input  logic              i_valid_e,
    input  logic              i_memread_e,
    input  logic [REG_AW-1:0] i_rd_e,
    input  logic [REG_AW-1:0] i_rs1_d,
    input  logic [REG_AW-1:0] i_rs2_d,
    input  logic              i_use_rs1_d,
    input  logic              i_use_rs2_d,
    output logic              o_hz
);

    logic w_rd_nonzero;
    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rd_nonzero = (i_rd_e != '0);
    assign w_rs1_match  = i_use_rs1_d && (i_rd_e == i_rs1_d);
    assign w_rs2_match  = i_use_rs2_d && (i_rd_e == i_rs2_d);

    assign o_hz = i_valid_d && i_valid_e && i_memread_e && w_rd_nonzero &&
                  (w_rs1_match || w_rs2_match);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : Decode-to-execute pipeline register with load-use hazard
//                detection. On a hazard it freezes PC and IF/ID and inserts a
//                bubble. It supports Flush (branch redirect) and Hold_e
//                (multi-cycle EX busy).
//  Options     : WB_BYPASS_EN - when defined, a same-cycle writeback to a
//                source register replaces the register file read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Valid_d,
    input  logic [REG_AW-1:0] Rs1_d,
    input  logic [REG_AW-1:0] Rs2_d,
    input  logic [REG_AW-1:0] Rd_d,
    input  logic              Use_rs1_d,
    input  logic              Use_rs2_d,
    input  logic [XLEN-1:0]   Read_data1,
    input  logic [XLEN-1:0]   Read_data2,
    input  logic [XLEN-1:0]   Imm_d,
    input  logic [XLEN-1:0]   PC_d,
    input  logic [CTRL_W-1:0] Ctrl_d,
    input  logic              Flush,
    input  logic              Hold_e,
    input  logic              WB_RegWrite,
    input  logic [REG_AW-1:0] WB_Rd,
    input  logic [XLEN-1:0]   WB_data,
    output logic              Valid_e,
    output logic [REG_AW-1:0] Rs1_e,
    output logic [REG_AW-1:0] Rs2_e,
    output logic [REG_AW-1:0] Rd_e,
    output logic [XLEN-1:0]   Op1_e,
    output logic [XLEN-1:0]   Op2_e,
    output logic [XLEN-1:0]   Imm_e,
    output logic [XLEN-1:0]   PC_e,
    output logic [CTRL_W-1:0] Ctrl_e,
    output logic              Stall_d
);

    import pipe_pkg::*;

    logic              r_valid;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [XLEN-1:0]   r_imm;
    logic [XLEN-1:0]   r_pc;
    logic [CTRL_W-1:0] r_ctrl;
    state_t            r_state;

    logic              w_hz;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;

    // Load-use detection between the EX-side load and the decode-slot sources
    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .i_valid_d   (Valid_d),
        .i_valid_e   (r_valid),
        .i_memread_e (r_ctrl[CTRL_MEMREAD]),
        .i_rd_e      (r_rd),
        .i_rs1_d     (Rs1_d),
        .i_rs2_d     (Rs2_d),
        .i_use_rs1_d (Use_rs1_d),
        .i_use_rs2_d (Use_rs2_d),
        .o_hz        (w_hz)
    );

`ifdef WB_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    // A writeback landing in the same cycle is not yet visible in the read data
    assign w_byp1 = WB_RegWrite && (WB_Rd != '0) && (WB_Rd == Rs1_d);
    assign w_byp2 = WB_RegWrite && (WB_Rd != '0) && (WB_Rd == Rs2_d);
    assign w_op1  = w_byp1 ? WB_data : Read_data1;
    assign w_op2  = w_byp2 ? WB_data : Read_data2;
`else
    logic w_unused_wb;

    // The writeback port stays present so both builds share one interface
    assign w_unused_wb = ^{WB_RegWrite, WB_Rd, WB_data};
    assign w_op1       = Read_data1;
    assign w_op2       = Read_data2;
`endif

    // A Flush kills the decode slot, so a hazard against it must not freeze fetch
    assign Stall_d = Hold_e || (w_hz && !Flush);

    // Pipeline register update in priority order: reset, flush, hold, bubble, capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
            r_ctrl  <= CTRL_NOP;
            r_state <= RUN;
        end else if (Flush) begin
            r_valid <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
            r_ctrl  <= CTRL_NOP;
            r_state <= RUN;
        end else if (Hold_e) begin
            r_valid <= r_valid;
            r_rs1   <= r_rs1;
            r_rs2   <= r_rs2;
            r_rd    <= r_rd;
            r_op1   <= r_op1;
            r_op2   <= r_op2;
            r_imm   <= r_imm;
            r_pc    <= r_pc;
            r_ctrl  <= r_ctrl;
            r_state <= r_state;
        end else if (w_hz) begin
            r_valid <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
            r_ctrl  <= CTRL_NOP;
            r_state <= LU_STALL;
        end else begin
            r_valid <= Valid_d;
            r_rs1   <= Rs1_d;
            r_rs2   <= Rs2_d;
            r_rd    <= Rd_d;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
            r_imm   <= Imm_d;
            r_pc    <= PC_d;
            r_ctrl  <= ctrl_gate(Valid_d, Ctrl_d);
            r_state <= RUN;
        end
    end

    assign Valid_e = r_valid;
    assign Rs1_e   = r_rs1;
    assign Rs2_e   = r_rs2;
    assign Rd_e    = r_rd;
    assign Op1_e   = r_op1;
    assign Op2_e   = r_op2;
    assign Imm_e   = r_imm;
    assign PC_e    = r_pc;
    assign Ctrl_e  = r_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage. It runs directed
//                scenarios and then a randomized run against a behavioural
//                model. It builds with or without WB_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Valid_d, Use_rs1_d, Use_rs2_d, Flush, Hold_e, WB_RegWrite;
    logic [4:0]  Rs1_d, Rs2_d, Rd_d, WB_Rd;
    logic [31:0] Read_data1, Read_data2, Imm_d, PC_d, WB_data;
    logic [9:0]  Ctrl_d;
    logic        Valid_e, Stall_d;
    logic [4:0]  Rs1_e, Rs2_e, Rd_e;
    logic [31:0] Op1_e, Op2_e, Imm_e, PC_e;
    logic [9:0]  Ctrl_e;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] c_rw, c_load;

    id_ex_stage #(.XLEN(32), .REG_AW(5), .CTRL_W(10)) dut (
        .clk(clk), .reset(reset), .Valid_d(Valid_d),
        .Rs1_d(Rs1_d), .Rs2_d(Rs2_d), .Rd_d(Rd_d),
        .Use_rs1_d(Use_rs1_d), .Use_rs2_d(Use_rs2_d),
        .Read_data1(Read_data1), .Read_data2(Read_data2),
        .Imm_d(Imm_d), .PC_d(PC_d), .Ctrl_d(Ctrl_d),
        .Flush(Flush), .Hold_e(Hold_e),
        .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd), .WB_data(WB_data),
        .Valid_e(Valid_e), .Rs1_e(Rs1_e), .Rs2_e(Rs2_e), .Rd_e(Rd_e),
        .Op1_e(Op1_e), .Op2_e(Op2_e), .Imm_e(Imm_e), .PC_e(PC_e),
        .Ctrl_e(Ctrl_e), .Stall_d(Stall_d)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        reset = 0; Valid_d = 0; Use_rs1_d = 0; Use_rs2_d = 0; Flush = 0; Hold_e = 0;
        WB_RegWrite = 0; Rs1_d = 0; Rs2_d = 0; Rd_d = 0; WB_Rd = 0;
        Read_data1 = 0; Read_data2 = 0; Imm_d = 0; PC_d = 0; WB_data = 0; Ctrl_d = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1; Valid_d = 1; Ctrl_d = 10'h3FF; Rd_d = 5'd3; Read_data1 = 32'h55;
        @(posedge clk); #1;
        n_checks++;
        if (Valid_e !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", Valid_e); end
        n_checks++;
        if (Ctrl_e !== 10'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 000", Ctrl_e); end
        n_checks++;
        if (Op1_e !== 32'h0) begin n_fail++; $display("FAIL reset_op1: got %h expected 0", Op1_e); end
        n_checks++;
        if (Stall_d !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", Stall_d); end
        n_checks++;
        if (dut.r_state !== RUN) begin n_fail++; $display("FAIL reset_state: got %b expected RUN", dut.r_state); end
    endtask

    task automatic test_capture();
        @(negedge clk);
        clear_inputs();
        Valid_d = 1; Rs1_d = 5'd10; Read_data1 = 32'd5; Imm_d = 32'd8; PC_d = 32'h100; Ctrl_d = c_rw;
        #1;
        n_checks++;
        if (Stall_d !== 1'b0) begin n_fail++; $display("FAIL capture_stall: got %b expected 0", Stall_d); end
        @(posedge clk); #1;
        n_checks++;
        if ({Valid_e, Rs1_e, Op1_e, Imm_e, PC_e} !== {1'b1, 5'd10, 32'd5, 32'd8, 32'h100}) begin
            n_fail++;
            $display("FAIL capture_fields: got v=%b rs1=%0d op1=%0d imm=%0d pc=%h expected v=1 rs1=10 op1=5 imm=8 pc=100",
                     Valid_e, Rs1_e, Op1_e, Imm_e, PC_e);
        end
        n_checks++;
        if (Ctrl_e[CTRL_REGWRITE] !== 1'b1) begin n_fail++; $display("FAIL capture_regwrite: got %b expected 1", Ctrl_e[CTRL_REGWRITE]); end
    endtask

    task automatic test_load_use(input logic [4:0] rd);
        @(negedge clk);
        clear_inputs();
        Valid_d = 1; Rd_d = rd; Ctrl_d = c_load;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        Valid_d = 1; Rs1_d = 5'd3; Use_rs1_d = 1; Rs2_d = rd; Use_rs2_d = 1; Rd_d = 5'd4;
        Read_data2 = 32'hABCD; Ctrl_d = c_rw | 10'(ALUOP_SUB);
        #1;
        n_checks++;
        if (Stall_d !== (rd != 0)) begin n_fail++; $display("FAIL loaduse_stall rd=%0d: got %b expected %b", rd, Stall_d, rd != 0); end
        @(posedge clk); #1;
        if (rd != 0) begin
            n_checks++;
            if ({Valid_e, Ctrl_e} !== 11'h0) begin n_fail++; $display("FAIL loaduse_bubble: got v=%b ctrl=%h expected v=0 ctrl=000", Valid_e, Ctrl_e); end
            n_checks++;
            if (dut.r_state !== LU_STALL) begin n_fail++; $display("FAIL loaduse_state: got %b expected LU_STALL", dut.r_state); end
            n_checks++;
            if (Stall_d !== 1'b0) begin n_fail++; $display("FAIL loaduse_stall_release: got %b expected 0", Stall_d); end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({Valid_e, Rs2_e, Rd_e, Op2_e} !== {1'b1, rd, 5'd4, 32'hABCD}) begin
            n_fail++;
            $display("FAIL loaduse_capture rd=%0d: got v=%b rs2=%0d rd=%0d op2=%h expected v=1 rs2=%0d rd=4 op2=abcd",
                     rd, Valid_e, Rs2_e, Rd_e, Op2_e, rd);
        end
        n_checks++;
        if (dut.r_state !== RUN) begin n_fail++; $display("FAIL loaduse_state_run: got %b expected RUN", dut.r_state); end
    endtask

    task automatic test_flush_vs_hazard();
        @(negedge clk);
        clear_inputs();
        Valid_d = 1; Rd_d = 5'd11; Ctrl_d = c_load;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        Valid_d = 1; Rs1_d = 5'd11; Use_rs1_d = 1; Read_data1 = 32'h77; Ctrl_d = c_rw; Flush = 1;
        #1;
        n_checks++;
        if (Stall_d !== 1'b0) begin n_fail++; $display("FAIL flush_hz_stall: got %b expected 0", Stall_d); end
        @(posedge clk); #1;
        n_checks++;
        if ({Valid_e, Ctrl_e, Op1_e, Rs1_e} !== 48'h0) begin
            n_fail++; $display("FAIL flush_hz_bubble: got v=%b ctrl=%h op1=%h rs1=%0d expected all 0", Valid_e, Ctrl_e, Op1_e, Rs1_e);
        end
        n_checks++;
        if (dut.r_state !== RUN) begin n_fail++; $display("FAIL flush_hz_state: got %b expected RUN", dut.r_state); end
    endtask

    task automatic test_hold();
        logic [31:0] d1;
        logic [4:0]  rd;
        @(negedge clk);
        clear_inputs();
        Valid_d = 1; Rd_d = 5'd7; Read_data1 = 32'h1111; Imm_d = 32'h22; Ctrl_d = c_rw;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            Hold_e = 1; Rd_d = 5'($urandom); Read_data1 = $urandom; Imm_d = $urandom; Ctrl_d = 10'($urandom);
            #1;
            n_checks++;
            if (Stall_d !== 1'b1) begin n_fail++; $display("FAIL hold_stall cyc=%0d: got %b expected 1", k, Stall_d); end
            @(posedge clk); #1;
            n_checks++;
            if ({Valid_e, Rd_e, Op1_e, Imm_e, Ctrl_e} !== {1'b1, 5'd7, 32'h1111, 32'h22, c_rw}) begin
                n_fail++;
                $display("FAIL hold_keep cyc=%0d: got v=%b rd=%0d op1=%h imm=%h ctrl=%h expected v=1 rd=7 op1=1111 imm=22 ctrl=%h",
                         k, Valid_e, Rd_e, Op1_e, Imm_e, Ctrl_e, c_rw);
            end
        end
        @(negedge clk);
        d1 = $urandom; rd = 5'($urandom);
        Hold_e = 0; Rd_d = rd; Read_data1 = d1; Ctrl_d = c_rw; Use_rs1_d = 0; Use_rs2_d = 0;
        @(posedge clk); #1;
        n_checks++;
        if ({Rd_e, Op1_e} !== {rd, d1}) begin
            n_fail++; $display("FAIL hold_release: got rd=%0d op1=%h expected rd=%0d op1=%h", Rd_e, Op1_e, rd, d1);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] e1, e2;
`ifdef WB_BYPASS_EN
        e1 = 32'hDEAD; e2 = 32'hDEAD;
`else
        e1 = 32'd7; e2 = 32'd9;
`endif
        @(negedge clk);
        clear_inputs();
        Valid_d = 1; WB_RegWrite = 1; WB_Rd = 5'd12; WB_data = 32'hDEAD;
        Rs1_d = 5'd12; Read_data1 = 32'd7; Rs2_d = 5'd12; Read_data2 = 32'd9;
        @(posedge clk); #1;
        n_checks++;
        if ({Op1_e, Op2_e} !== {e1, e2}) begin
            n_fail++; $display("FAIL bypass_hit: got op1=%h op2=%h expected op1=%h op2=%h", Op1_e, Op2_e, e1, e2);
        end
        @(negedge clk);
        WB_Rd = 5'd0; Rs1_d = 5'd0; Rs2_d = 5'd0;
        @(posedge clk); #1;
        n_checks++;
        if ({Op1_e, Op2_e} !== {32'd7, 32'd9}) begin
            n_fail++; $display("FAIL bypass_x0: got op1=%h op2=%h expected op1=7 op2=9", Op1_e, Op2_e);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        clear_inputs();
        Valid_d = 1; Rd_d = 5'd5; Ctrl_d = c_load;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        Valid_d = 1; Rs1_d = 5'd5; Use_rs1_d = 1; Ctrl_d = c_rw;
        @(posedge clk); #1;
        n_checks++;
        if (dut.r_state !== LU_STALL) begin n_fail++; $display("FAIL midstall_enter: got %b expected LU_STALL", dut.r_state); end
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        n_checks++;
        if ({Valid_e, Ctrl_e} !== 11'h0) begin n_fail++; $display("FAIL midstall_nop: got v=%b ctrl=%h expected v=0 ctrl=000", Valid_e, Ctrl_e); end
        n_checks++;
        if (dut.r_state !== RUN) begin n_fail++; $display("FAIL midstall_state: got %b expected RUN", dut.r_state); end
        @(negedge clk);
        reset = 0;
        #1;
        n_checks++;
        if (Stall_d !== 1'b0) begin n_fail++; $display("FAIL midstall_stall: got %b expected 0", Stall_d); end
    endtask

    // Randomized run against a model of the stage's observable contents
    task automatic test_random();
        bit          m_valid, m_lu, hz, exp_stall, prev_lu;
        logic [4:0]  m_rs1, m_rs2, m_rd;
        logic [31:0] m_op1, m_op2, m_imm, m_pc;
        logic [9:0]  m_ctrl;
        m_valid = 0; m_lu = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_op1 = 0; m_op2 = 0; m_imm = 0; m_pc = 0; m_ctrl = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            reset       = (i == 0) || ($urandom_range(0, 49) == 0);
            Flush       = ($urandom_range(0, 9) == 0);
            Hold_e      = ($urandom_range(0, 6) == 0);
            Valid_d     = ($urandom_range(0, 3) != 0);
            Rs1_d       = 5'($urandom_range(0, 3));
            Rs2_d       = 5'($urandom_range(0, 3));
            Rd_d        = 5'($urandom_range(0, 3));
            Use_rs1_d   = 1'($urandom);
            Use_rs2_d   = 1'($urandom);
            Read_data1  = $urandom; Read_data2 = $urandom;
            Imm_d       = $urandom; PC_d = $urandom;
            Ctrl_d      = 10'($urandom);
            WB_RegWrite = 1'($urandom);
            WB_Rd       = 5'($urandom_range(0, 3));
            WB_data     = $urandom;
            #1;
            hz = m_valid && Valid_d && m_ctrl[CTRL_MEMREAD] && (m_rd != 0) &&
                 ((Use_rs1_d && m_rd == Rs1_d) || (Use_rs2_d && m_rd == Rs2_d));
            exp_stall = Hold_e || (hz && !Flush);
            if (i != 0) begin
                n_checks++;
                if (Stall_d !== exp_stall) begin n_fail++; $display("FAIL rand_stall i=%0d: got %b expected %b", i, Stall_d, exp_stall); end
            end
            prev_lu = (dut.r_state == LU_STALL);
            if (reset || Flush || (!Hold_e && hz)) begin
                m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op1 = 0; m_op2 = 0;
                m_imm = 0; m_pc = 0; m_ctrl = 0;
                m_lu = !reset && !Flush;
            end else if (!Hold_e) begin
                m_valid = Valid_d; m_rs1 = Rs1_d; m_rs2 = Rs2_d; m_rd = Rd_d;
                m_imm = Imm_d; m_pc = PC_d; m_ctrl = Valid_d ? Ctrl_d : 10'h0;
                m_op1 = Read_data1; m_op2 = Read_data2;
`ifdef WB_BYPASS_EN
                if (WB_RegWrite && WB_Rd != 0 && WB_Rd == Rs1_d) m_op1 = WB_data;
                if (WB_RegWrite && WB_Rd != 0 && WB_Rd == Rs2_d) m_op2 = WB_data;
`endif
                m_lu = 0;
            end
            @(posedge clk); #1;
            n_checks++;
            if ({Valid_e, Rs1_e, Rs2_e, Rd_e, Op1_e, Op2_e, Imm_e, PC_e, Ctrl_e} !==
                {m_valid, m_rs1, m_rs2, m_rd, m_op1, m_op2, m_imm, m_pc, m_ctrl}) begin
                n_fail++;
                $display("FAIL rand_regs i=%0d: got v=%b rs=%0d/%0d rd=%0d op=%h/%h imm=%h pc=%h ctrl=%h expected v=%b rs=%0d/%0d rd=%0d op=%h/%h imm=%h pc=%h ctrl=%h",
                         i, Valid_e, Rs1_e, Rs2_e, Rd_e, Op1_e, Op2_e, Imm_e, PC_e, Ctrl_e,
                         m_valid, m_rs1, m_rs2, m_rd, m_op1, m_op2, m_imm, m_pc, m_ctrl);
            end
            n_checks++;
            if ((dut.r_state == LU_STALL) !== m_lu) begin n_fail++; $display("FAIL rand_state i=%0d: got %b expected lu=%b", i, dut.r_state, m_lu); end
            if (prev_lu && (!Hold_e || reset)) begin
                n_checks++;
                if (dut.r_state !== RUN) begin n_fail++; $display("FAIL rand_lu_twice i=%0d: got %b expected RUN", i, dut.r_state); end
            end
            if (!Valid_e) begin
                n_checks++;
                if ({Ctrl_e[CTRL_REGWRITE], Ctrl_e[CTRL_MEMWRITE]} !== 2'b00) begin
                    n_fail++; $display("FAIL rand_bubble_side_effect i=%0d: got ctrl=%h expected RegWrite=0 MemWrite=0", i, Ctrl_e);
                end
            end
        end
    endtask

    initial begin
        c_rw   = 10'b1 << CTRL_REGWRITE;
        c_load = (10'b1 << CTRL_REGWRITE) | (10'b1 << CTRL_MEMREAD) | (10'b1 << CTRL_MEMTOREG) |
                 (10'b1 << CTRL_ALUSRC);
        clear_inputs();
        test_reset();
        test_capture();
        test_load_use(5'd11);
        test_load_use(5'd0);
        test_flush_vs_hazard();
        test_hold();
        test_bypass();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline register for the pipelined processor core. It captures the two register file read ports, the immediate, the PC, the destination and source indices and the decoded control word, and presents them to EX one cycle later. It also contains the load-use hazard detector. On a hazard it freezes IF/ID and PC and inserts a bubble. It supports a Flush input (branch redirect) and a Hold input (multi-cycle EX busy).

Parameters:
XLEN, 32, datapath width.
REG_AW, 5, register index width.
CTRL_W, 10, control word width (bit layout defined in pipe_pkg).

Ports:
clk  in  1  core clock.
reset  in  1  synchronous, active-high reset.
Valid_d  in  1  decode slot holds a real instruction.
Rs1_d, Rs2_d, Rd_d  in  REG_AW  decoded register indices.
Use_rs1_d, Use_rs2_d  in  1  instruction actually reads Rs1/Rs2.
Read_data1, Read_data2  in  XLEN  register file read data.
Imm_d, PC_d  in  XLEN  immediate and PC.
Ctrl_d  in  CTRL_W  control bits: RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, ALUOp[3:0].
Flush  in  1  kill decode slot and EX register contents.
Hold_e  in  1  EX busy; freeze this stage.
WB_RegWrite  in  1  writeback enable.
WB_Rd  in  REG_AW  writeback index.
WB_data  in  XLEN  writeback data.
Valid_e  out  1  EX slot valid.
Rs1_e, Rs2_e, Rd_e  out  REG_AW  registered indices.
Op1_e, Op2_e  out  XLEN  registered operands.
Imm_e, PC_e  out  XLEN  registered immediate and PC.
Ctrl_e  out  CTRL_W  registered control word.
Stall_d  out  1  freeze PC and IF/ID (combinational).

Behaviour:
- All registered outputs update on the rising edge of clk only. Latency is one cycle from D inputs to E outputs.
- Reset is synchronous. It clears every registered output to 0 (Valid_e=0, Ctrl_e=0 = NOP) and puts the FSM in RUN.
- Hazard condition (combinational):
  - hz = Valid_d & Valid_e & Ctrl_e.MemRead & (Rd_e!=0) & ((Use_rs1_d & Rd_e==Rs1_d) | (Use_rs2_d & Rd_e==Rs2_d)).
  - Register x0 never matches.
- Stall_d = Hold_e | (hz & ~Flush).
- Per-edge update priority:
  1. reset.
  2. Flush: load a bubble (Valid_e=0, Ctrl_e=0, all data fields 0).
  3. Hold_e: keep all registers unchanged.
  4. hz: load a bubble.
  5. Otherwise, capture the D inputs. If Valid_d=0, Ctrl_e is forced to 0.
- FSM states:
  - RUN to LU_STALL when a bubble is inserted because of hz.
  - LU_STALL to RUN on the next non-Hold edge. hz is guaranteed false there, because EX now holds the bubble.
  - Any state to RUN on reset or Flush.
  - LU_STALL lasts exactly one cycle unless extended by Hold_e.
  - The state has no output effect beyond its debug visibility. The bench checks that it never stays in LU_STALL for 2 consecutive non-Hold edges.
- A bubble must never carry RegWrite or MemWrite.
- Flush and hz in the same cycle: Flush wins and Stall_d=0.
- Hold_e and hz in the same cycle: registers hold, Stall_d=1.
- Reset asserted mid-stall: the next edge gives RUN and a NOP, with Stall_d=0 the cycle after.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - When capturing, if WB_RegWrite & WB_Rd!=0 & WB_Rd==Rs1_d, then Op1_e <= WB_data, otherwise Read_data1. Same rule for Op2_e with Rs2_d.
  - This covers a same-cycle writeback to the register file.
- Undefined:
  - Op1_e/Op2_e always take Read_data1/Read_data2.
  - The WB_* ports remain present but are ignored.

Decomposition:
- pipe_pkg holds:
  - CTRL_W and the bit index constants for each control field.
  - The ALUOp encodings.
  - CTRL_NOP = 0.
  - The FSM state typedef (RUN, LU_STALL).
- One combinational sub-module, hazard_detect, produces hz from the E-side and D-side fields. It is reused later by the forwarding unit.

Test Plan:
- Reset then idle: after reset, Valid_e=0, Ctrl_e=0, Stall_d=0. Apply Valid_d=1, Rs1_d=10, Read_data1=5, Imm_d=8, RegWrite set. Next edge gives Op1_e=5, Imm_e=8, Valid_e=1, Ctrl_e.RegWrite=1.
- Load-use: an EX load with Rd_e=11, followed by a decode with Rs2_d=11 and Use_rs2_d=1. Stall_d=1 for one cycle, the next edge gives Valid_e=0 and Ctrl_e=0, then the instruction is captured on the following edge. The same sequence with Rd_e=0 gives no stall.
- Flush vs hazard: hz and Flush in the same cycle give Stall_d=0 and a bubble on the edge, with the FSM in RUN.
- Hold: Hold_e=1 for 3 cycles while the D inputs change. The E outputs stay constant and Stall_d=1 throughout. After release, the current D inputs are captured.
- Bypass (WB_BYPASS_EN): WB_RegWrite=1, WB_Rd=12, WB_data=0xDEAD, Rs1_d=12, Read_data1=7. With the macro, Op1_e=0xDEAD. Without it, Op1_e=7. With WB_Rd=0, Op1_e=7 in both builds.
- Reset mid-stall: assert reset during LU_STALL. The next edge gives a NOP in EX and the FSM in RUN.
